ex_hazard_controller: RTL and testbench
=======================================

Name: ex_hazard_controller

Overview:
- Sequences the EX stage operand path and the front-end pipeline registers.
- Tracks destination registers of instructions in EX/MEM/WB using an internal shadow pipeline.
- Registers the A_sel/B_sel forwarding selects so they are valid when the ID instruction enters EX.
- Detects load-use hazards (stall plus bubble) and branch mispredicts (multi-cycle flush).

Parameters:
- REG_ADDR_W, 5, register index width.
- FLUSH_CYCLES, 2, cycles flush_if_id/flush_id_ex stay asserted after a mispredict (1..15).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- id_rs1  input  REG_ADDR_W  ID source A index
- id_rs2  input  REG_ADDR_W  ID source B index
- id_rd  input  REG_ADDR_W  ID destination index
- id_reg_write  input  1  ID instruction writes rd
- id_mem_read  input  1  ID instruction is a load
- ex_branch_valid  input  1  EX holds a resolved branch/jump this cycle
- ex_isValid  input  1  EX prediction check result, 1 = correct
- A_sel  output  2  registered EX operand-A select
- B_sel  output  2  registered EX operand-B select
- stall_if_id  output  1  hold PC and IF/ID
- flush_if_id  output  1  clear IF/ID
- flush_id_ex  output  1  insert bubble into ID/EX
- busy_flush  output  1  flush counter non-zero

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- Reset values:
  - All shadow stages invalid, rd=0, flags=0.
  - A_sel=B_sel=00, flush counter=0.
  - All control outputs 0.
- Select encoding:
  - 00 = register file value.
  - 01 = Data_MEM.
  - 10 = Data_WB.
  - 11 is never driven.
- Shadow pipeline: stages EXs, MEMs, WBs, each holding {valid, rd, reg_write, mem_read}.
  - Every clock: WBs<=MEMs, MEMs<=EXs.
  - EXs<=ID fields, or a bubble (valid=0) when flush_id_ex or stall_if_id is asserted.
- Forward decision, made combinationally in ID and registered into A_sel/B_sel, evaluated per source rs:
  - rs==0 -> 00. x0 is never forwarded.
  - EXs.valid & EXs.reg_write & EXs.rd==rs & !EXs.mem_read -> 01. The producer is in MEM when the consumer reaches EX.
  - Else MEMs.valid & MEMs.reg_write & MEMs.rd==rs -> 10.
  - Else 00.
  - The youngest producer wins when several match.
- Load-use hazard:
  - Condition: id_valid & EXs.valid & EXs.mem_read & EXs.reg_write & EXs.rd!=0 & rd matches id_rs1 or id_rs2.
  - Response: stall_if_id=1 and flush_id_ex=1, both combinational, for exactly 1 cycle.
  - The next cycle re-evaluates with the load in MEMs and selects 10.
- Mispredict:
  - Trigger: ex_branch_valid & !ex_isValid.
  - flush_if_id and flush_id_ex assert combinationally in the same cycle.
  - The counter loads FLUSH_CYCLES-1. Both flushes stay high while counter!=0, and the counter decrements each cycle.
  - busy_flush = (counter!=0).
  - A new mispredict during a flush reloads the counter.
- Priority: mispredict/flush over load-use. stall_if_id is forced 0 while either flush is asserted.
- Selects registered during a flush or stall are don't-care and are driven 00.
- id_valid=0 -> no stall, selects 00.

Optional Feature:
- Macro HAZARD_PERF_EN. When defined, adds two outputs:
  - stall_count [31:0]: increments on each cycle stall_if_id=1.
  - flush_count [31:0]: increments on each mispredict trigger.
  - Both reset to 0 and wrap at 2^32.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: drive reset=0 mid-run during an active flush -> all outputs 0 immediately. Counter 0 after release.
- EX-to-EX forward: ADD x5 (reg_write) in ID, next cycle ID rs1=5 -> A_sel=01 the following cycle, B_sel=00. Repeat with rs2=5 -> B_sel=01.
- Two-back forward and priority:
  - x7 written by two consecutive instructions, consumer rs1=7 -> A_sel=01 (younger wins).
  - With only the older producer -> A_sel=10.
  - rs1=0 with rd=0 producer -> 00.
- Load-use: LW x3 then ADD rs2=3 -> one cycle of stall_if_id=1, flush_id_ex=1. Next cycle no stall, and the registered B_sel=10.
- Mispredict with FLUSH_CYCLES=2: ex_branch_valid=1, ex_isValid=0 -> flush_if_id=flush_id_ex=1 for 2 cycles, busy_flush=1 for the second only. A simultaneous load-use yields stall_if_id=0.
- HAZARD_PERF_EN: the above sequence gives stall_count=1 and flush_count=1. A second mispredict mid-flush -> flush_count=2 and the counter reloads.

Source files
------------

// File: rtl/ex_hazard_controller.sv
// EX-stage hazard controller: shadow EX/MEM/WB destination tracking, registered
// operand forwarding selects, load-use stall and multi-cycle mispredict flush.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
module ex_hazard_controller #(
   parameter int REG_ADDR_W   = 5,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  ex_branch_valid,
   input  logic                  ex_isValid,
   output logic [1:0]            A_sel,
   output logic [1:0]            B_sel,
   output logic                  stall_if_id,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
`ifdef HAZARD_PERF_EN
   output logic [31:0]           stall_count,
   output logic [31:0]           flush_count,
`endif
   output logic                  busy_flush
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
   } stage_t;

   localparam stage_t STAGE_NONE = '{valid: 1'b0, rd: {REG_ADDR_W{1'b0}},
                                     reg_write: 1'b0, mem_read: 1'b0};
   localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

   // Index 0 = EXs, 1 = MEMs, 2 = WBs
   stage_t     shadow_q [3];
   stage_t     shadow_d [3];
   logic [3:0] cnt_q, cnt_d;
   logic [1:0] a_sel_q, a_sel_d, b_sel_q, b_sel_d;
   logic       mispredict_s, flush_s, load_use_s, stall_s, bubble_s;

   // A load in EXs cannot supply MEM-stage data yet, so it is skipped here.
   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                          input stage_t ex_st, input stage_t mem_st);
      logic [1:0] sel;
      if (rs == {REG_ADDR_W{1'b0}}) begin
         sel = 2'b00;
      end else if (ex_st.valid && ex_st.reg_write && (ex_st.rd == rs) && !ex_st.mem_read) begin
         sel = 2'b01;
      end else if (mem_st.valid && mem_st.reg_write && (mem_st.rd == rs)) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Hazard detection, flush sequencing, shadow advance and select computation.
   always_comb begin
      mispredict_s = ex_branch_valid && !ex_isValid;
      flush_s      = mispredict_s || (cnt_q != 4'd0);
      load_use_s   = id_valid && shadow_q[0].valid && shadow_q[0].mem_read &&
                     shadow_q[0].reg_write && (shadow_q[0].rd != {REG_ADDR_W{1'b0}}) &&
                     ((shadow_q[0].rd == id_rs1) || (shadow_q[0].rd == id_rs2));
      stall_s      = load_use_s && !flush_s;
      bubble_s     = flush_s || stall_s;

      if (mispredict_s) begin
         cnt_d = FLUSH_RELOAD;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end else begin
         cnt_d = 4'd0;
      end

      shadow_d[2] = shadow_q[1];
      shadow_d[1] = shadow_q[0];
      if (bubble_s) begin
         shadow_d[0] = STAGE_NONE;
      end else begin
         shadow_d[0] = '{valid: id_valid, rd: id_rd,
                         reg_write: id_reg_write, mem_read: id_mem_read};
      end

      if (bubble_s || !id_valid) begin
         a_sel_d = 2'b00;
         b_sel_d = 2'b00;
      end else begin
         a_sel_d = fwd_sel(id_rs1, shadow_q[0], shadow_q[1]);
         b_sel_d = fwd_sel(id_rs2, shadow_q[0], shadow_q[1]);
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) begin
            shadow_q[i] <= STAGE_NONE;
         end
         cnt_q   <= 4'd0;
         a_sel_q <= 2'b00;
         b_sel_q <= 2'b00;
      end else begin
         for (int i = 0; i < 3; i++) begin
            shadow_q[i] <= shadow_d[i];
         end
         cnt_q   <= cnt_d;
         a_sel_q <= a_sel_d;
         b_sel_q <= b_sel_d;
      end
   end

   assign A_sel       = a_sel_q;
   assign B_sel       = b_sel_q;
   assign stall_if_id = stall_s;
   assign flush_if_id = flush_s;
   assign flush_id_ex = bubble_s;
   assign busy_flush  = (cnt_q != 4'd0);

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;

   // Event counters; both wrap naturally at 2^32.
   always_comb begin
      stall_count_d = stall_s      ? (stall_count_q + 32'd1) : stall_count_q;
      flush_count_d = mispredict_s ? (flush_count_q + 32'd1) : flush_count_q;
   end

   // Counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count_q <= 32'd0;
         flush_count_q <= 32'd0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Directed self-checking bench for ex_hazard_controller (FLUSH_CYCLES=2).
module tb_ex_hazard_controller;
   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_reg_write, id_mem_read;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       ex_branch_valid, ex_isValid;
   logic [1:0] A_sel, B_sel;
   logic       stall_if_id, flush_if_id, flush_id_ex, busy_flush;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_count, flush_count;
`endif

   int checks = 0;
   int errors = 0;

   ex_hazard_controller #(.REG_ADDR_W(5), .FLUSH_CYCLES(2)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .ex_branch_valid(ex_branch_valid), .ex_isValid(ex_isValid),
      .A_sel(A_sel), .B_sel(B_sel),
      .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
`ifdef HAZARD_PERF_EN
      .stall_count(stall_count), .flush_count(flush_count),
`endif
      .busy_flush(busy_flush)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic rw, input logic mr);
      id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_reg_write = rw; id_mem_read = mr;
   endtask

   task automatic br(input logic bv, input logic iv);
      ex_branch_valid = bv; ex_isValid = iv;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctl(input string tag, input logic st, input logic fif,
                          input logic fid, input logic bsy);
      chk({tag, "_stall"}, {31'd0, stall_if_id}, {31'd0, st});
      chk({tag, "_fif"},   {31'd0, flush_if_id}, {31'd0, fif});
      chk({tag, "_fid"},   {31'd0, flush_id_ex}, {31'd0, fid});
      chk({tag, "_busy"},  {31'd0, busy_flush},  {31'd0, bsy});
   endtask

   initial begin
      reset = 1'b0;
      id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      br(1'b0, 1'b1);
      #3;
      chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_a", {30'd0, A_sel}, 32'd0);
      chk("rst_b", {30'd0, B_sel}, 32'd0);
      @(negedge clk) reset = 1'b1;
      tick();

      // EX-to-EX forward on rs1, then on rs2
      id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0); tick();
      id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0); tick();
      chk("exex_a", {30'd0, A_sel}, 32'd1);
      chk("exex_b", {30'd0, B_sel}, 32'd0);
      id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0); tick();
      chk("exex_a0", {30'd0, A_sel}, 32'd0);
      id(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0); tick();
      chk("exex_b2", {30'd0, B_sel}, 32'd1);
      chk("exex_a2", {30'd0, A_sel}, 32'd0);

      // Two producers of x7: younger wins
      id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0); tick();
      id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0); tick();
      id(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0); tick();
      chk("young_a", {30'd0, A_sel}, 32'd1);
      // Only the older producer matches
      id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0); tick();
      id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0); tick();
      id(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0); tick();
      chk("old_a", {30'd0, A_sel}, 32'd2);
      // x0 never forwarded
      id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); tick();
      id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
      chk("x0_a", {30'd0, A_sel}, 32'd0);
      chk("x0_b", {30'd0, B_sel}, 32'd0);
      // Invalid ID gives 00 selects despite a match
      id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0); tick();
      id(1'b0, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0); tick();
      chk("inv_a", {30'd0, A_sel}, 32'd0);
      chk("inv_b", {30'd0, B_sel}, 32'd0);

      // Load-use: LW x3 then ADD rs2=3
      id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1); tick();
      id(1'b1, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0); #2;
      chk_ctl("lu1", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk("lu_b_stall", {30'd0, B_sel}, 32'd0);
      #1;
      chk_ctl("lu2", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("lu_b_mem", {30'd0, B_sel}, 32'd2);
      chk("lu_a_mem", {30'd0, A_sel}, 32'd0);

      // Mispredict coinciding with a load-use hazard
      id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1); tick();
      id(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0); br(1'b1, 1'b0); #2;
      chk_ctl("mp1", 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      br(1'b0, 1'b1); #1;
      chk_ctl("mp2", 1'b0, 1'b1, 1'b1, 1'b1);
      chk("mp_a1", {30'd0, A_sel}, 32'd0);
      tick();
      chk("mp_a2", {30'd0, A_sel}, 32'd0);
      id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
      chk_ctl("mp3", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_EN
      chk("perf_stall", stall_count, 32'd1);
      chk("perf_flush1", flush_count, 32'd1);
`endif

      // Second mispredict mid-flush reloads the counter
      br(1'b1, 1'b0); tick();
      #1;
      chk_ctl("rl1", 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      br(1'b0, 1'b1); #1;
      chk_ctl("rl2", 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      #1;
      chk_ctl("rl3", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_EN
      chk("perf_flush3", flush_count, 32'd3);
`endif

      // Asynchronous reset during an active flush
      br(1'b1, 1'b0); tick();
      br(1'b0, 1'b1); #1;
      reset = 1'b0; #1;
      chk_ctl("arst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("arst_a", {30'd0, A_sel}, 32'd0);
      chk("arst_b", {30'd0, B_sel}, 32'd0);
`ifdef HAZARD_PERF_EN
      chk("arst_sc", stall_count, 32'd0);
      chk("arst_fc", flush_count, 32'd0);
`endif
      @(negedge clk) reset = 1'b1;
      tick();
      #1;
      chk_ctl("post", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
